port_sched: RTL
===============

# port_sched

Per-output-port read scheduler for the 16-port switch. Each output port holds 8 priority queues, selected by the 3-bit priority field of the packet header. This block decides which queue the read datapath serves next, issues a one-cycle grant, and holds off further grants until the datapath reports end of packet. One instance sits in front of each output port's read engine.

## Interface
Parameters:
- PRI_NUM, 8, number of priority queues; queue index equals header priority, and 7 is the highest priority.
- CRD_W, 4, width of each WRR credit counter; must hold PRI_NUM.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- wrr_en  in  1  1 selects weighted round robin; 0 selects strict priority. Sampled only in IDLE.
- q_nonempty  in  PRI_NUM  bit q set means queue q holds at least one complete packet.
- ready  in  1  the downstream port can accept a packet. Level signal, sampled in IDLE.
- pkt_done  in  1  single-cycle pulse from the read engine on the last beat (rd_eop) of the granted packet.
- grant  out  PRI_NUM  one-hot selected queue. Valid while busy=1; zero otherwise.
- grant_vld  out  1  one-cycle pulse marking the start of a grant.
- busy  out  1  a grant is outstanding.

## Operation
- States:
  - IDLE: grant=0, busy=0. If ready=1 and q_nonempty!=0, select a queue, register it into grant, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: lasts exactly one cycle. grant_vld=1, busy=1. If pkt_done=1, go to IDLE; otherwise go to WAIT_DONE.
  - WAIT_DONE: grant held, busy=1. On pkt_done=1, go to IDLE.
- pkt_done received in IDLE is ignored.
- q_nonempty changes after selection do not alter grant.
- Strict priority (wrr_en=0): select the highest-index set bit of q_nonempty.
  - Credits are reloaded every IDLE cycle while wrr_en=0, so entering WRR always starts a fresh round.
- WRR (wrr_en=1):
  - Credit counter crd[q] reloads to q+1, so queue q receives at most q+1 grants per round.
  - Eligible set: q_nonempty & (crd!=0).
  - If the eligible set is empty, this is a round rollover: all credits are treated as reloaded and the eligible set becomes q_nonempty.
  - Scan order runs ascending and modular, starting at ptr+1. The first eligible queue wins.
  - On selection: ptr takes the winning index, and crd[winner] decrements. On a rollover, the winner's credit is set to winner, and every other credit is set to q+1.
- Reset: state=IDLE, grant=0, grant_vld=0, busy=0, ptr=PRI_NUM-1, crd[q]=q+1.
  - Reset asserted mid-grant drops busy and grant asynchronously.
  - Credits and ptr are restored.
- Width rules: ptr is $clog2(PRI_NUM) bits and wraps from PRI_NUM-1 to 0. Credits never underflow because only eligible queues decrement.

## Timing
- ready=1 and a nonempty queue sampled at edge N give grant_vld=1 and a valid grant in cycle N+1 (between edges N and N+1).
- busy rises at edge N with grant_vld. It falls at the edge after pkt_done is sampled.
- pkt_done sampled at edge M returns the block to IDLE at M. The earliest next grant_vld is in cycle M+2, because IDLE must sample ready first.
- pkt_done in the GRANT cycle is legal (single-beat packet). busy then lasts exactly 1 cycle.
- Grants are never back-to-back. There is at least one IDLE cycle between consecutive grant_vld pulses.
- Selection logic is combinational from registered crd/ptr and the sampled q_nonempty. Outputs are registered.

## Test plan
- Reset: assert rst mid-run, including during WAIT_DONE. Required: grant=0, grant_vld=0 and busy=0 immediately, without waiting for a clock edge. After release, the first WRR grant with q_nonempty=8'hFF is queue 0.
- Strict priority: wrr_en=0, q_nonempty=8'h18, ready pulsed for one cycle. Required: grant_vld in the next cycle, and grant=8'h10 (queue 4). After pkt_done, a second ready gives grant=8'h10 again.
- WRR credits: wrr_en=1, q_nonempty=8'h03 held, ready=1, pkt_done returned 3 cycles after each grant. Required grant sequence: q0, q1, q1, then rollover, then q0, q1, q1.
- Empty/idle: ready=1 with q_nonempty=0 for 10 cycles. Required: no grant_vld, and busy stays 0. Setting bit 2 then produces grant=8'h04 one cycle later.
- Single-beat packet: pkt_done asserted in the GRANT cycle. Required: busy high for exactly 1 cycle, and the next grant_vld no earlier than 2 cycles after pkt_done.
- Mode switch: switch wrr_en 1→0 while in WAIT_DONE. Required: the current grant is held until pkt_done. The next grant is strict priority. Returning to WRR restarts full credits, with ptr kept.

Source files
------------

// File: rtl/port_sched.sv
// port_sched: per-output-port read scheduler, strict priority or WRR across PRI_NUM queues
module port_sched #(
  parameter int PRI_NUM = 8,
  parameter int CRD_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrr_en,
  input  logic [PRI_NUM-1:0] q_nonempty,
  input  logic               ready,
  input  logic               pkt_done,
  output logic [PRI_NUM-1:0] grant,
  output logic               grant_vld,
  output logic               busy
);
  localparam int PW = (PRI_NUM > 1) ? $clog2(PRI_NUM) : 1;
  localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, WAIT_DONE = 2'd2;
  logic [1:0] state;
  logic [PW-1:0] ptr, sp_win, rr_win, idx, win;
  logic [CRD_W-1:0] crd [PRI_NUM];
  logic [PRI_NUM-1:0] crd_nz, elig, cand;
  logic roll, take;
  always_comb begin
    sp_win = '0;
    rr_win = '0;
    idx = '0;
    crd_nz = '0;
    for (int q = 0; q < PRI_NUM; q++) begin
      crd_nz[q] = crd[q] != '0;
      if (q_nonempty[q]) sp_win = PW'(q);
    end
    elig = q_nonempty & crd_nz;
    roll = elig == '0;
    cand = roll ? q_nonempty : elig;
    // scan backwards so the last hit is the first queue after ptr
    for (int k = PRI_NUM; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % PRI_NUM);
      if (cand[idx]) rr_win = idx;
    end
    win = wrr_en ? rr_win : sp_win;
    take = state == IDLE && ready && q_nonempty != '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_vld <= 1'b0;
      busy <= 1'b0;
      ptr <= PW'(PRI_NUM - 1);
      for (int q = 0; q < PRI_NUM; q++) crd[q] <= CRD_W'(q + 1);
    end else begin
      grant_vld <= take;
      if (state == IDLE) begin
        if (!wrr_en) for (int q = 0; q < PRI_NUM; q++) crd[q] <= CRD_W'(q + 1);
        if (take) begin
          state <= GRANT;
          grant <= PRI_NUM'(1) << win;
          busy <= 1'b1;
          if (wrr_en) begin
            ptr <= win;
            if (roll) for (int q = 0; q < PRI_NUM; q++) crd[q] <= (q == int'(win)) ? CRD_W'(q) : CRD_W'(q + 1);
            else crd[win] <= crd[win] - CRD_W'(1);
          end
        end
      end else if (pkt_done) begin
        state <= IDLE;
        grant <= '0;
        busy <= 1'b0;
      end else if (state == GRANT) begin
        state <= WAIT_DONE;
      end
    end
  end
endmodule
